// File: rtl/shufflenetv2_div_seq_u22u10.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Valid/ready on both sides; a single operation in flight; fixed latency regardless of operands.
module shufflenetv2_div_seq_u22u10 #(
  parameter int DIVIDEND_W = 22,
  parameter int DIVISOR_W  = 10
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  input  logic [DIVISOR_W-1:0]  in_divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_quot,
  output logic [DIVISOR_W-1:0]  out_rem,
  output logic                  out_dbz,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DIVIDEND_W-1:0] dvd_reg;
  logic [DIVISOR_W-1:0]  dsr_reg;
  logic [DIVISOR_W-1:0]  part_reg;
  logic                  dbz_reg;

  logic [DIVISOR_W:0]    part_shift;
  logic [DIVISOR_W-1:0]  part_sub;
  logic                  q_bit;
  logic                  last_iter;
  logic                  accept;
  logic                  release_res;

  // The shifted partial needs one extra bit before the compare; after a
  // conditional subtract it is always below the divisor and fits DIVISOR_W.
  assign part_shift  = {part_reg, dvd_reg[DIVIDEND_W-1]};
  assign q_bit       = (part_shift >= {1'b0, dsr_reg});
  assign part_sub    = q_bit ? DIVISOR_W'(part_shift - {1'b0, dsr_reg})
                             : part_shift[DIVISOR_W-1:0];
  assign last_iter   = (cnt_reg == CNT_W'(DIVIDEND_W - 1));
  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (release_res) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

  // Quotient bits are shifted into the dividend register as its bits are consumed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_reg  <= '0;
      dvd_reg  <= '0;
      dsr_reg  <= '0;
      part_reg <= '0;
      dbz_reg  <= 1'b0;
      out_quot <= '0;
      out_rem  <= '0;
      out_dbz  <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg  <= '0;
        dvd_reg  <= in_dividend;
        dsr_reg  <= in_divisor;
        part_reg <= '0;
        dbz_reg  <= (in_divisor == '0);
      end else if (state_reg == CALC) begin
        cnt_reg  <= cnt_reg + 1'b1;
        dvd_reg  <= {dvd_reg[DIVIDEND_W-2:0], q_bit};
        part_reg <= part_sub;
        if (last_iter) begin
          out_quot <= dbz_reg ? '1 : {dvd_reg[DIVIDEND_W-2:0], q_bit};
          out_rem  <= dbz_reg ? '0 : part_sub;
          out_dbz  <= dbz_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_shufflenetv2_div_seq_u22u10.sv
// Randomised self-checking bench for the sequential divider, compared against
// plain integer division in the bench.
module tb_shufflenetv2_div_seq_u22u10;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [21:0] in_dividend = '0;
  logic [9:0]  in_divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [21:0] out_quot;
  logic [9:0]  out_rem;
  logic        out_dbz;
  logic        busy;

  int checks = 0;
  int failures = 0;

  shufflenetv2_div_seq_u22u10 dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_quot    (out_quot),
    .out_rem     (out_rem),
    .out_dbz     (out_dbz),
    .busy        (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference: integer division with the divide-by-zero convention.
  function automatic longint ref_q(input longint a, input longint b);
    return (b == 0) ? 64'h3FFFFF : a / b;
  endfunction

  function automatic longint ref_r(input longint a, input longint b);
    return (b == 0) ? 0 : a % b;
  endfunction

  // Issue one operation; stall = cycles out_ready stays low in DONE (-1: out_ready held high).
  // verbose prints one line for the transaction.
  task automatic run_op(input longint a, input longint b, input int stall, input bit verbose);
    int lat;
    int waitc;
    logic [21:0] q_hold;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      step();
      waitc++;
    end
    check("in_ready_wait", in_ready, 1);
    in_dividend = a[21:0];
    in_divisor  = b[9:0];
    in_valid    = 1'b1;
    out_ready   = (stall < 0);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (lat == 3) begin
        check("busy_calc", busy, 1);
        check("in_ready_calc", in_ready, 0);
      end
      step();
      lat++;
    end
    check("latency", lat, 22);
    check("quot", out_quot, ref_q(a, b));
    check("rem", out_rem, ref_r(a, b));
    check("dbz", out_dbz, (b == 0) ? 1 : 0);
    if (verbose)
      $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, out_quot, out_rem, out_dbz, lat);
    if (stall >= 0) begin
      q_hold = out_quot;
      // New requests during DONE must be ignored.
      in_valid    = 1'b1;
      in_dividend = 22'd999;
      in_divisor  = 10'd3;
      for (int i = 0; i < stall; i++) step();
      check("hold_valid", out_valid, 1);
      check("hold_quot", out_quot, q_hold);
      check("hold_rem", out_rem, ref_r(a, b));
      check("hold_in_ready", in_ready, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    step();
    // With out_ready held high the result edge is 23 edges after the accept edge.
    check("released", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    if (stall < 0) check("occupancy", lat + 1, 23);
    out_ready = 1'b0;
    check("idle_keep_quot", out_quot, ref_q(a, b));
  endtask

  initial begin
    longint a, b;
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quot", out_quot, 0);
    check("rst_rem", out_rem, 0);
    check("rst_dbz", out_dbz, 0);
    ap_rst_n = 1'b1;
    step();

    run_op(1000, 7, 0, 1);
    run_op(4194303, 1023, 0, 1);
    run_op(5, 9, 0, 1);
    run_op(0, 1, 0, 1);
    run_op(4194303, 1, 0, 1);
    run_op(12345, 0, 0, 1);
    run_op(12345, 5, 0, 1);
    run_op(500000, 37, 5, 1);
    run_op(1023, 1023, -1, 1);

    // Abandon an operation by reset partway through the iterations.
    in_dividend = 22'd1000;
    in_divisor  = 10'd7;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    ap_rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_quot", out_quot, 0);
    check("midrst_rem", out_rem, 0);
    check("midrst_dbz", out_dbz, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid) check("midrst_no_result", out_valid, 0);
    end
    $display("reset mid-op: abandoned, out_valid=%0d", out_valid);
    run_op(77, 11, 0, 1);

    // Round trip through the multiplier domain, back-to-back.
    for (int i = 0; i < 1500; i++) begin
      a = longint'($urandom_range(4095, 0));
      b = longint'($urandom_range(1023, 1));
      run_op(a * b, b, -1, 0);
    end
    $display("round trip: 1500 ops done");

    // Random dividends and divisors, including occasional zero divisors.
    for (int i = 0; i < 800; i++) begin
      a = longint'($urandom_range(4194303, 0));
      b = ($urandom_range(15, 0) == 0) ? 0 : longint'($urandom_range(1023, 1));
      run_op(a, b, int'($urandom_range(3, 0)) - 1, 0);
    end
    $display("random: 800 ops done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
